// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_pkg
// Description : Shared types and constants for the LED pattern engine.
//               Holds the mode codes, the 3-bit mode type, the step-period
//               type and the bounce direction type.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    localparam int MODE_W = 3;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF    = 3'd0;
    localparam mode_t MODE_ON     = 3'd1;
    localparam mode_t MODE_BLINK  = 3'd2;
    localparam mode_t MODE_ALT    = 3'd3;
    localparam mode_t MODE_CHASE  = 3'd4;
    localparam mode_t MODE_BOUNCE = 3'd5;

    // Default width of the ms-per-step field.
    localparam int STEP_PERIOD_W = 16;
    typedef logic [STEP_PERIOD_W-1:0] step_period_t;

    // Travel direction of the bounce pattern.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_step_timer
// Description : Counts 1 ms ticks and fires a step every iPeriod ticks.
//               A period of 0 behaves as 1 (step on every tick). iClear
//               restarts the count and suppresses any step in that cycle.
// Ports       : clk, rstN (async, active-low), iTick1ms (1 ms pulse),
//               iClear (restart), iPeriod (ticks per step),
//               oStepFire (combinational, high in the tick cycle that steps)
// Revision    : 1.0 - initial release
// ============================================================================
module led_step_timer
    import led_pattern_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                iTick1ms,
    input  logic                iClear,
    input  logic [PERIOD_W-1:0] iPeriod,
    output logic                oStepFire
);

    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_last;
    logic                w_at_last;

    // Terminal count; period 0 collapses onto period 1.
    always_comb begin
        w_last = '0;
        if (iPeriod != '0) begin
            w_last = iPeriod - 1'b1;
        end
    end

    // ">=" keeps the counter from running away should the period ever
    // shrink below the current count.
    assign w_at_last = (r_cnt >= w_last);
    assign oStepFire = iTick1ms && !iClear && w_at_last;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt <= '0;
        end else if (iClear) begin
            r_cnt <= '0;
        end else if (iTick1ms) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_ctrl
// Description : Multi-channel LED pattern engine. Steps OFF/ON/BLINK/ALT/
//               CHASE/BOUNCE patterns from the shared 1 ms tick and drives
//               NUM_LED active-low outputs. Reset defaults give a 1 Hz blink
//               of all LEDs.
// Ports       : clk, rstN (async, active-low), iTick1ms (1 ms pulse),
//               iCfgLoad (config strobe), iMode (mode code),
//               iHalfPeriodMs (ms per step), iBright (brightness, PWM build),
//               oLed (active-low drive), oStep (step pulse), oMode (stored)
// Options     : LED_PWM_DIM_EN - gates lit LEDs with a 16-slot PWM against
//               iBright. Undefined: lit LEDs are held low continuously.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int NUM_LED         = 8,
    parameter int PERIOD_W        = 16,
    parameter int DEFAULT_HALF_MS = 500,
    parameter int RESET_MODE      = 2
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                iTick1ms,
    input  logic                iCfgLoad,
    input  logic [2:0]          iMode,
    input  logic [PERIOD_W-1:0] iHalfPeriodMs,
    input  logic [3:0]          iBright,
    output logic [NUM_LED-1:0]  oLed,
    output logic                oStep,
    output logic [2:0]          oMode
);

    localparam int                 c_POS_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(NUM_LED - 1);

    // Configuration registers
    mode_t               r_mode;
    logic [PERIOD_W-1:0] r_period;

    // Pattern state
    logic                r_phase;
    logic [c_POS_W-1:0]  r_pos;
    dir_t                r_dir;
    logic                w_phase_nxt;
    logic [c_POS_W-1:0]  w_pos_nxt;
    dir_t                w_dir_nxt;

    logic                w_step_fire;
    logic [NUM_LED-1:0]  w_lit;
    logic [NUM_LED-1:0]  w_drive;
    logic [NUM_LED-1:0]  r_led;
    logic                r_step;

    // ------------------------------------------------------------------
    // Step timer
    // ------------------------------------------------------------------
    led_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_step_timer (
        .clk       (clk),
        .rstN      (rstN),
        .iTick1ms  (iTick1ms),
        .iClear    (iCfgLoad),
        .iPeriod   (r_period),
        .oStepFire (w_step_fire)
    );

    // ------------------------------------------------------------------
    // Configuration registers: sampled only on the strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mode   <= mode_t'(RESET_MODE);
            r_period <= PERIOD_W'(DEFAULT_HALF_MS);
        end else if (iCfgLoad) begin
            r_mode   <= iMode;
            r_period <= iHalfPeriodMs;
        end
    end

    // ------------------------------------------------------------------
    // Pattern state: register process
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_phase <= 1'b0;
            r_pos   <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_phase <= w_phase_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pattern state: next-state process. A config load restarts the
    // pattern and wins over a coincident step. Position advances in every
    // mode; the bounce rule is used only in BOUNCE, otherwise it rotates.
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_nxt = r_phase;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        if (iCfgLoad) begin
            w_phase_nxt = 1'b0;
            w_pos_nxt   = '0;
            w_dir_nxt   = DIR_UP;
        end else if (w_step_fire) begin
            w_phase_nxt = ~r_phase;
            if (NUM_LED > 1) begin
                if (r_mode == MODE_BOUNCE) begin
                    case (r_dir)
                        DIR_UP: begin
                            if (r_pos == c_LAST_POS) begin
                                w_dir_nxt = DIR_DOWN;
                                w_pos_nxt = r_pos - 1'b1;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end
                        default: begin
                            if (r_pos == '0) begin
                                w_dir_nxt = DIR_UP;
                                w_pos_nxt = r_pos + 1'b1;
                            end else begin
                                w_pos_nxt = r_pos - 1'b1;
                            end
                        end
                    endcase
                end else begin
                    w_pos_nxt = (r_pos == c_LAST_POS) ? '0 : r_pos + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode decoder (1 = logically lit). Codes 6 and 7 decode as OFF.
    // ------------------------------------------------------------------
    always_comb begin
        w_lit = '0;
        case (r_mode)
            MODE_ON: begin
                w_lit = '1;
            end
            MODE_BLINK: begin
                w_lit = {NUM_LED{r_phase}};
            end
            MODE_ALT: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    w_lit[i] = ((i % 2) == 1) ? r_phase : ~r_phase;
                end
            end
            MODE_CHASE, MODE_BOUNCE: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    w_lit[i] = (r_pos == c_POS_W'(i));
                end
            end
            default: begin
                w_lit = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Brightness gating, folded into the output register input
    // ------------------------------------------------------------------
`ifdef LED_PWM_DIM_EN
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_drive = w_lit & {NUM_LED{(r_pwm_cnt <= iBright)}};
`else
    // Brightness has no function without PWM dimming.
    logic w_unused_bright;
    assign w_unused_bright = ^iBright;
    assign w_drive         = w_lit;
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_led  <= '1;
            r_step <= 1'b0;
        end else begin
            r_led  <= ~w_drive;
            r_step <= w_step_fire;
        end
    end

    assign oLed  = r_led;
    assign oStep = r_step;
    assign oMode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Self-checking bench for led_pattern_ctrl. Randomised tick
//               timing and config loads are compared every clock against a
//               reference model that derives the pattern from the number of
//               steps taken since the last load or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int N   = 8;
    localparam int PW  = 16;
    localparam int DEF = 500;
    localparam int RM  = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          iTick1ms;
    logic          iCfgLoad;
    logic [2:0]    iMode;
    logic [PW-1:0] iHalfPeriodMs;
    logic [3:0]    iBright;
    logic [N-1:0]  oLed;
    logic          oStep;
    logic [2:0]    oMode;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .NUM_LED         (N),
        .PERIOD_W        (PW),
        .DEFAULT_HALF_MS (DEF),
        .RESET_MODE      (RM)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .iTick1ms      (iTick1ms),
        .iCfgLoad      (iCfgLoad),
        .iMode         (iMode),
        .iHalfPeriodMs (iHalfPeriodMs),
        .iBright       (iBright),
        .oLed          (oLed),
        .oStep         (oStep),
        .oMode         (oMode)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode, period, steps since restart, ticks into step
    int m_mode;
    int m_period;
    int m_k;
    int m_tcnt;
    int m_pwm;
    int ticks_total = 0;

    function automatic logic [N-1:0] f_lit(input int mode, input int k);
        logic [N-1:0] lit;
        int pos;
        lit = '0;
        case (mode)
            1: lit = '1;
            2: lit = ((k % 2) == 1) ? '1 : '0;
            3: for (int i = 0; i < N; i++) lit[i] = ((i % 2) == (k % 2));
            4: lit[k % N] = 1'b1;
            5: begin
                if (N == 1) begin
                    pos = 0;
                end else begin
                    pos = k % (2 * N - 2);
                    if (pos >= N) pos = 2 * N - 2 - pos;
                end
                lit[pos] = 1'b1;
            end
            default: lit = '0;
        endcase
        return lit;
    endfunction

    task automatic m_reset();
        m_mode   = RM;
        m_period = DEF;
        m_k      = 0;
        m_tcnt   = 0;
        m_pwm    = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock: drive inputs, update the model across the edge, check.
    task automatic cyc(input bit tick, input bit load, input int mode, input int period);
        logic [N-1:0] exp_led;
        bit           fire;
        iTick1ms = tick;
        iCfgLoad = load;
        iBright  = 4'($urandom_range(0, 15));
        if (load) begin
            iMode         = 3'(mode);
            iHalfPeriodMs = PW'(period);
        end else begin
            iMode         = 3'($urandom_range(0, 7));
            iHalfPeriodMs = PW'($urandom_range(0, 9));
        end
        @(posedge clk);
        exp_led = ~f_lit(m_mode, m_k);
`ifdef LED_PWM_DIM_EN
        if (m_pwm > int'(iBright)) exp_led = '1;
        m_pwm = (m_pwm + 1) % 16;
`endif
        fire = 1'b0;
        if (load) begin
            m_mode   = mode;
            m_period = period;
            m_k      = 0;
            m_tcnt   = 0;
        end else if (tick) begin
            ticks_total++;
            m_tcnt++;
            if (m_tcnt >= ((m_period == 0) ? 1 : m_period)) begin
                m_tcnt = 0;
                m_k++;
                fire = 1'b1;
            end
        end
        #1;
        chk("led",  32'(oLed),  32'(exp_led));
        chk("step", 32'(oStep), 32'(fire));
        chk("mode", 32'(oMode), 32'(m_mode));
    endtask

    function automatic bit rtick();
        return ($urandom_range(0, 1) == 1);
    endfunction

    initial begin
        int t0;
        rstN          = 1'b0;
        iTick1ms      = 1'b0;
        iCfgLoad      = 1'b0;
        iMode         = '0;
        iHalfPeriodMs = '0;
        iBright       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  32'(oLed),  32'hFF);
        chk("rst_step", 32'(oStep), 32'h0);
        chk("rst_mode", 32'(oMode), 32'(RM));
        m_reset();
        @(negedge clk);
        rstN = 1'b1;

        // Default blink with no load
        while (ticks_total < 1050) cyc(rtick(), 1'b0, 0, 0);

        // Chase, period 3
        cyc(1'b0, 1'b1, 4, 3);
        repeat (100) cyc(rtick(), 1'b0, 0, 0);

        // Bounce, period 1
        cyc(1'b0, 1'b1, 5, 1);
        repeat (60) cyc(rtick(), 1'b0, 0, 0);

        // Load coincident with a tick mid-count
        cyc(1'b0, 1'b1, 2, 5);
        repeat (7) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 3, 4);
        repeat (40) cyc(rtick(), 1'b0, 0, 0);

        // Period 0, then an undefined mode code
        cyc(1'b0, 1'b1, 2, 0);
        repeat (20) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 7, 2);
        repeat (10) cyc(rtick(), 1'b0, 0, 0);

        // Random loads and runs, loads sometimes landing on ticks
        repeat (30) begin
            cyc(rtick(), 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
            repeat ($urandom_range(10, 60)) cyc(rtick(), 1'b0, 0, 0);
        end

        // Async reset mid-pattern, then recovery to default blink
        cyc(1'b0, 1'b1, 4, 2);
        repeat (20) cyc(1'b1, 1'b0, 0, 0);
        rstN = 1'b0;
        #2;
        chk("arst_led",  32'(oLed),  32'hFF);
        chk("arst_step", 32'(oStep), 32'h0);
        chk("arst_mode", 32'(oMode), 32'(RM));
        m_reset();
        @(negedge clk);
        rstN = 1'b1;
        t0 = ticks_total;
        while (ticks_total < t0 + 520) cyc(rtick(), 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
